// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, stream header
// default and the widths of the checksum accumulator and word counter.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        HI,
        LO,
        WRITE,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam int         CHK_W        = 8;
    localparam int         CNT_W        = 9;

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: parses SYNC, count, high/low byte pairs and an
// XOR checksum, writing each word to instruction memory while the CPU is held.
module prog_loader
    import loader_pkg::*;
#(
    parameter int         ADDR_W    = 8,
    parameter int         DATA_W    = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              im_we,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t           state;
    state_t           state_nxt;
    logic [CHK_W-1:0] chk;
    logic [CNT_W-1:0] count;
    logic             ready_st;
    logic             accept;

    // Ready depends only on state; reset gating is applied on the output alone.
    assign ready_st = (state == IDLE) || (state == LEN) || (state == HI) ||
                      (state == LO)   || (state == CHK);
    assign accept   = rx_valid && ready_st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept && (rx_data == SYNC_BYTE)) state_nxt = LEN;
            LEN:     if (accept) state_nxt = HI;
            HI:      if (accept) state_nxt = LO;
            LO:      if (accept) state_nxt = WRITE;
            // A count of 1 here means this write is the last word.
            WRITE:   state_nxt = (count == CNT_W'(1)) ? CHK : HI;
            CHK:     if (accept) state_nxt = (rx_data == chk) ? DONE : ERR;
            DONE:    if (load_req) state_nxt = IDLE;
            ERR:     if (load_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rx_ready = reset && ready_st;
        im_we    = (state == WRITE);
        cpu_hold = (state != DONE);
        done     = (state == DONE);
        error    = (state == ERR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_addr  <= '0;
            im_wdata <= '0;
            chk      <= '0;
            count    <= '0;
        end else begin
            case (state)
                LEN: begin
                    if (accept) begin
                        count   <= (rx_data == 8'd0) ? CNT_W'(256) : {1'b0, rx_data};
                        im_addr <= '0;
                        chk     <= '0;
                    end
                end
                HI: begin
                    if (accept) begin
                        im_wdata[DATA_W-1 -: 8] <= rx_data;
                        chk                     <= chk ^ rx_data;
                    end
                end
                LO: begin
                    if (accept) begin
                        im_wdata[7:0] <= rx_data;
                        chk           <= chk ^ rx_data;
                    end
                end
                // Address wraps naturally after a full 256-word load.
                WRITE: begin
                    im_addr <= im_addr + 1'b1;
                    count   <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory address width.
REQ-002 Parameter DATA_W, default 16, instruction width; loaded as two bytes.
REQ-003 Parameter SYNC_BYTE, default 8'hA5, stream header byte.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  byte from host link.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader can accept a byte; a byte transfers when rx_valid and rx_ready are both 1 on a rising edge.
REQ-009 load_req  input  1  one-cycle pulse that re-arms the loader from DONE or ERR.
REQ-010 im_addr  output  ADDR_W  instruction-memory write address.
REQ-011 im_wdata  output  DATA_W  instruction-memory write data.
REQ-012 im_we  output  1  one-cycle instruction-memory write strobe.
REQ-013 cpu_hold  output  1  1 holds the processor in reset while a program loads.
REQ-014 done  output  1  load completed with a good checksum.
REQ-015 error  output  1  load failed with a checksum mismatch.

Function
REQ-016 Stream format: SYNC_BYTE, count byte N (0 means 256), 2N payload bytes with the high byte first per instruction, then a checksum byte equal to the XOR of all 2N payload bytes.
REQ-017 FSM states: IDLE, LEN, HI, LO, WRITE, CHK, DONE, ERR.
REQ-018 IDLE: on an accepted byte equal to SYNC_BYTE, go to LEN; discard other bytes and stay in IDLE.
REQ-019 LEN: latch N into a 9-bit remaining-word counter, with 0 loaded as 256; clear the address and checksum; go to HI.
REQ-020 HI: latch the byte into im_wdata[15:8] and XOR it into the checksum; go to LO.
REQ-021 LO: latch the byte into im_wdata[7:0] and XOR it into the checksum; go to WRITE.
REQ-022 WRITE: assert im_we for exactly one cycle with stable im_addr and im_wdata, then increment im_addr (mod 2^ADDR_W) and decrement the counter; go to CHK if the counter reaches 0, else go to HI.
REQ-023 rx_ready is 1 in IDLE, LEN, HI, LO and CHK, and 0 in WRITE, DONE and ERR; a byte offered while rx_ready is 0 is neither consumed nor lost.
REQ-024 CHK: an accepted byte equal to the checksum goes to DONE; any other byte goes to ERR.
REQ-025 DONE: done=1 and cpu_hold=0.
REQ-026 ERR: error=1 and cpu_hold=1.
REQ-027 load_req in DONE or ERR goes to IDLE, clears done and error, and sets cpu_hold=1; load_req is ignored in all other states.
REQ-028 cpu_hold is 1 in every state except DONE.
REQ-029 Per-word throughput is 3 cycles minimum (HI, LO, WRITE), with no bubbles when rx_valid is held high.
REQ-030 The 256-word load ends with im_addr wrapped to 0; this wrap is legal and not an error.

Reset
REQ-031 Reset asserted (low), asynchronously: state=IDLE, im_addr=0, im_wdata=0, im_we=0, rx_ready=0 while reset is held, cpu_hold=1, done=0, error=0, checksum=0, counter=0.
REQ-032 After reset releases, rx_ready=1 (IDLE) from the first clock edge.
REQ-033 Reset mid-stream abandons the partial load; the next load starts at address 0, and words already written are not rolled back.

Structure
REQ-034 Shared package loader_pkg holds the state enumeration, SYNC_BYTE default and the checksum width constant.
REQ-035 Single module with no sub-module; the checksum is an inline XOR accumulator.

Verification
REQ-036 Stream A5 02 12 34 56 78 08 -> im_we twice (addr 0 = 1234, addr 1 = 5678); then done=1, cpu_hold=0, error=0.
REQ-037 Same stream with checksum byte 09 -> both writes occur; then error=1, cpu_hold=1, done=0; load_req -> IDLE with error=0.
REQ-038 Bytes 00 FF 3C, then A5 01 AB CD 66 -> junk ignored; one write (addr 0 = ABCD); done=1.
REQ-039 A5 00, then 512 bytes, then correct checksum -> exactly 256 im_we pulses at addresses 00..FF; im_addr ends at 0; done=1.
REQ-040 Reset pulsed low after the first payload byte of A5 02 ... -> all outputs at reset values immediately; a following full stream writes from address 0.
REQ-041 rx_valid held high for the whole stream -> rx_ready low only in WRITE; no byte dropped or duplicated; 3 cycles per word.
